// File: rtl/key_event_conditioner.sv
// Key event conditioner: synchronises and debounces raw active-low KEY pins
// and turns each one into a clean level plus single-cycle press, release and
// long-press events for the downstream state machines.
module key_event_conditioner #(
  parameter int N_KEYS            = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int CNT_W             = 26
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Last debounce count before a change is accepted, and the hold count one
  // cycle before the long-press threshold is reached.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PREV = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_KEYS-1:0] sync_a;
  logic [N_KEYS-1:0] sync_b;
  logic [N_KEYS-1:0] key_on;

  // Two-flop synchroniser per key; resets to the released (high) pin level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= KEY;
      sync_b <= sync_a;
    end
  end

  assign key_on = ~sync_b;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    state_t           state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_inc;
    logic             long_done;
    logic             long_hit;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic             long_r;

    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
    assign long_hit = !long_done && (hcnt == LONG_PREV);

    // Per-channel debounce FSM with hold timer and registered event pulses.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state     <= IDLE;
        dcnt      <= '0;
        hcnt      <= '0;
        long_done <= 1'b0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (state)
          IDLE: begin
            long_done <= 1'b0;
            if (key_on[g]) begin
              state <= PRESS_WAIT;
              dcnt  <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!key_on[g]) begin
              state <= IDLE;
              dcnt  <= '0;
            end else if (dcnt == DEB_LAST) begin
              state   <= HELD;
              dcnt    <= '0;
              level_r <= 1'b1;
              press_r <= 1'b1;
              hcnt    <= '0;
            end else begin
              dcnt <= dcnt + CNT_ONE;
            end
          end
          HELD: begin
            hcnt <= hcnt_inc;
            if (long_hit) begin
              long_r    <= 1'b1;
              long_done <= 1'b1;
            end
            if (!key_on[g]) begin
              state <= RELEASE_WAIT;
              dcnt  <= CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (!key_on[g] && (dcnt == DEB_LAST)) begin
              state     <= IDLE;
              dcnt      <= '0;
              level_r   <= 1'b0;
              release_r <= 1'b1;
              hcnt      <= '0;
              long_done <= 1'b0;
            end else begin
              hcnt <= hcnt_inc;
              if (long_hit) begin
                long_r    <= 1'b1;
                long_done <= 1'b1;
              end
              if (key_on[g]) begin
                state <= HELD;
                dcnt  <= '0;
              end else begin
                dcnt <= dcnt + CNT_ONE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign key_level[g]   = level_r;
    assign key_press[g]   = press_r;
    assign key_release[g] = release_r;
    assign key_long[g]    = long_r;
  end

endmodule
